shiftreg_xfer: RTL and testbench

Full-duplex, parametrised shift engine that grows the basic load/shift register into a complete word-transfer block. A word is accepted with a valid/ready handshake and shifted out LANES bits per step in either direction while serial data is shifted in. After WIDTH/LANES steps the received word is posted to an output holding register with its own valid/ready handshake. It sits between a parallel bus-side producer/consumer and a serial (1/2/4-lane) link front end.

---
 rtl/shiftreg_xfer.sv | 166 ++++++++++++++++
 tb/tb_shiftreg_xfer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_xfer.sv
`default_nettype none
// ============================================================================
// Module   : shiftreg_xfer
// Purpose  : Full-duplex load/shift word-transfer engine. Accepts a parallel
//            word over valid/ready, shifts it out LANES bits per step while
//            shifting serial data in, then posts the received word to a
//            holding register with its own valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module shiftreg_xfer #(
  parameter int WIDTH    = 10,
  parameter int LANES    = 1,
  parameter bit LEFT     = 1'b0,
  parameter bit IDLE_OUT = 1'b1,
  localparam int STEPS   = WIDTH / LANES,
  localparam int CW      = $clog2(STEPS + 1)
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             load_valid_in,
  output logic             load_ready_out,
  input  logic [WIDTH-1:0] pdata_in,
  input  logic             shift_in,
  input  logic             abort_in,
  input  logic [LANES-1:0] sdata_in,
  output logic [LANES-1:0] sdata_out,
  output logic [WIDTH-1:0] pdata_out,
  output logic             cap_valid_out,
  input  logic             cap_ready_in,
  output logic             done_out,
  output logic             overrun_out,
  output logic             busy_out,
  output logic [CW-1:0]    count_out
);

  localparam logic [CW-1:0] C_LAST_CNT  = CW'(STEPS - 1);
  localparam logic [CW-1:0] C_STEPS_CNT = CW'(STEPS);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   pdata_q, pdata_d;
  logic               cap_valid_q, cap_valid_d;
  logic               done_q, done_d;
  logic               overrun_q, overrun_d;

  logic [WIDTH-1:0]   w_shifted;
  logic [LANES-1:0]   w_tx_lanes;
  logic               w_last;
  logic               w_load_ready;

  // Direction-dependent shift path and outgoing lane selection
  generate
    if (LEFT) begin : g_left
      if (WIDTH == LANES) begin : g_full
        assign w_shifted = sdata_in;
      end else begin : g_part
        assign w_shifted = {shreg_q[WIDTH-LANES-1:0], sdata_in};
      end
      assign w_tx_lanes = shreg_q[WIDTH-1 -: LANES];
    end else begin : g_right
      if (WIDTH == LANES) begin : g_full
        assign w_shifted = sdata_in;
      end else begin : g_part
        assign w_shifted = {sdata_in, shreg_q[WIDTH-1:LANES]};
      end
      assign w_tx_lanes = shreg_q[LANES-1:0];
    end
  endgenerate

  assign w_last = (count_q == C_LAST_CNT);

  // Next-state logic: load, shift, completion, abort and holding register
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    count_d      = count_q;
    pdata_d      = pdata_q;
    cap_valid_d  = cap_valid_q;
    done_d       = 1'b0;
    overrun_d    = overrun_q;
    w_load_ready = 1'b0;

    // A pop frees the holding register unless a capture lands the same cycle
    if (cap_valid_q && cap_ready_in) begin
      cap_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        w_load_ready = 1'b1;
        count_d      = '0;
        if (load_valid_in) begin
          shreg_d = pdata_in;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort_in) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (shift_in) begin
          shreg_d = w_shifted;
          count_d = count_q + CW'(1);
          if (w_last) begin
            w_load_ready = 1'b1;
            pdata_d      = w_shifted;
            cap_valid_d  = 1'b1;
            done_d       = 1'b1;
            if (cap_valid_q && !cap_ready_in) begin
              overrun_d = 1'b1;
            end
            count_d = C_STEPS_CNT;
            state_d = ST_IDLE;
            // Back-to-back: next word starts with no idle gap
            if (load_valid_in) begin
              shreg_d = pdata_in;
              count_d = '0;
              state_d = ST_SHIFT;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      count_q     <= '0;
      pdata_q     <= '0;
      cap_valid_q <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      count_q     <= count_d;
      pdata_q     <= pdata_d;
      cap_valid_q <= cap_valid_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign load_ready_out = w_load_ready;
  assign sdata_out      = (state_q == ST_SHIFT) ? w_tx_lanes : {LANES{IDLE_OUT}};
  assign pdata_out      = pdata_q;
  assign cap_valid_out  = cap_valid_q;
  assign done_out       = done_q;
  assign overrun_out    = overrun_q;
  assign busy_out       = (state_q == ST_SHIFT);
  assign count_out      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_shiftreg_xfer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shiftreg_xfer
// Purpose  : Self-checking bench for shiftreg_xfer. Instance A is 10-bit,
//            1 lane, MSB first; instance B is 10-bit, 2 lanes, LSB first with
//            IDLE_OUT = 0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shiftreg_xfer;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;

  // Instance A signals
  logic       a_lv, a_lr, a_sh, a_ab, a_cr, a_cv, a_done, a_ovr, a_busy;
  logic [9:0] a_pd, a_po;
  logic [0:0] a_sdi, a_sdo;
  logic [3:0] a_cnt;

  // Instance B signals
  logic       b_lv, b_lr, b_sh, b_ab, b_cr, b_cv, b_done, b_ovr, b_busy;
  logic [9:0] b_pd, b_po;
  logic [1:0] b_sdi, b_sdo;
  logic [2:0] b_cnt;

  shiftreg_xfer #(.WIDTH(10), .LANES(1), .LEFT(1'b1), .IDLE_OUT(1'b1)) u_dut_a (
    .clock_in(clk), .reset_in(rst),
    .load_valid_in(a_lv), .load_ready_out(a_lr), .pdata_in(a_pd),
    .shift_in(a_sh), .abort_in(a_ab), .sdata_in(a_sdi), .sdata_out(a_sdo),
    .pdata_out(a_po), .cap_valid_out(a_cv), .cap_ready_in(a_cr),
    .done_out(a_done), .overrun_out(a_ovr), .busy_out(a_busy), .count_out(a_cnt)
  );

  shiftreg_xfer #(.WIDTH(10), .LANES(2), .LEFT(1'b0), .IDLE_OUT(1'b0)) u_dut_b (
    .clock_in(clk), .reset_in(rst),
    .load_valid_in(b_lv), .load_ready_out(b_lr), .pdata_in(b_pd),
    .shift_in(b_sh), .abort_in(b_ab), .sdata_in(b_sdi), .sdata_out(b_sdo),
    .pdata_out(b_po), .cap_valid_out(b_cv), .cap_ready_in(b_cr),
    .done_out(b_done), .overrun_out(b_ovr), .busy_out(b_busy), .count_out(b_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit position of lane group k of a 10-bit word: MSB-first groups start at
  // the top, LSB-first groups start at bit 0. Outgoing group k and incoming
  // group k occupy the same position of their respective words.
  function automatic int lane_pos(int k, int lanes, bit left);
    return left ? (10 - lanes * (k + 1)) : (lanes * k);
  endfunction

  function automatic logic [3:0] lane_of(logic [9:0] w, int k, int lanes, bit left);
    int v;
    v = (int'(w) >> lane_pos(k, lanes, left)) & ((1 << lanes) - 1);
    return v[3:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // One complete word on instance A; rxw is the word fed in serially
  task automatic xfer_a(input logic [9:0] word, input logic [9:0] rxw,
                        input bit stalls, input bit crdy_last);
    logic [3:0] l;
    a_lv = 1'b1; a_pd = word; a_sh = 1'b0; a_ab = 1'b0; #1;
    total++; if (a_lr !== 1'b1) begin bad++; $display("FAIL a_load_ready_idle got=%0b exp=1", a_lr); end
    tick;
    a_lv = 1'b0;
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL a_busy_after_load got=%0b exp=1", a_busy); end
    for (int k = 0; k < 10; k++) begin
      l = lane_of(word, k, 1, 1'b1);
      if (stalls) begin
        while ($urandom_range(0, 3) == 0) begin
          a_sh = 1'b0; #1;
          total++; if (a_sdo !== l[0:0] || a_cnt !== 4'(k)) begin bad++;
            $display("FAIL a_stall k=%0d sdo=%0b cnt=%0d exp sdo=%0b cnt=%0d", k, a_sdo, a_cnt, l[0], k); end
          tick;
        end
      end
      a_sh = 1'b1;
      a_sdi = lane_of(rxw, k, 1, 1'b1) & 4'h1 ? 1'b1 : 1'b0;
      if (k == 9) a_cr = crdy_last;
      #1;
      total++; if (a_sdo !== l[0:0]) begin bad++; $display("FAIL a_sdata_out k=%0d got=%0b exp=%0b", k, a_sdo, l[0]); end
      total++; if (a_cnt !== 4'(k) || a_done !== 1'b0) begin bad++;
        $display("FAIL a_step_state k=%0d cnt=%0d done=%0b exp cnt=%0d done=0", k, a_cnt, a_done, k); end
      total++; if (a_lr !== (k == 9)) begin bad++; $display("FAIL a_load_ready k=%0d got=%0b exp=%0b", k, a_lr, (k == 9)); end
      tick;
    end
    a_sh = 1'b0; a_sdi = 1'b0;
    total++; if (a_done !== 1'b1 || a_cnt !== 4'd10 || a_cv !== 1'b1 || a_busy !== 1'b0) begin bad++;
      $display("FAIL a_complete done=%0b cnt=%0d cv=%0b busy=%0b exp 1 10 1 0", a_done, a_cnt, a_cv, a_busy); end
    total++; if (a_po !== rxw) begin bad++; $display("FAIL a_pdata_out got=%03h exp=%03h", a_po, rxw); end
    total++; if (a_sdo !== 1'b1) begin bad++; $display("FAIL a_idle_out got=%0b exp=1", a_sdo); end
    tick;
    total++; if (a_done !== 1'b0 || a_cnt !== 4'd0) begin bad++;
      $display("FAIL a_after_done done=%0b cnt=%0d exp 0 0", a_done, a_cnt); end
  endtask

  // One complete word on instance B (2 lanes, LSB first)
  task automatic xfer_b(input logic [9:0] word, input logic [9:0] rxw);
    logic [3:0] l;
    b_lv = 1'b1; b_pd = word; b_sh = 1'b0; b_cr = 1'b1;
    tick;
    b_lv = 1'b0;
    for (int k = 0; k < 5; k++) begin
      l = lane_of(word, k, 2, 1'b0);
      b_sh = 1'b1;
      b_sdi = 2'(lane_of(rxw, k, 2, 1'b0));
      #1;
      total++; if (b_sdo !== l[1:0] || b_cnt !== 3'(k)) begin bad++;
        $display("FAIL b_step k=%0d sdo=%0b cnt=%0d exp sdo=%0b cnt=%0d", k, b_sdo, b_cnt, l[1:0], k); end
      tick;
    end
    b_sh = 1'b0; b_sdi = 2'b00;
    total++; if (b_po !== rxw || b_done !== 1'b1 || b_cnt !== 3'd5) begin bad++;
      $display("FAIL b_complete po=%03h done=%0b cnt=%0d exp po=%03h 1 5", b_po, b_done, b_cnt, rxw); end
    total++; if (b_sdo !== 2'b00 || b_busy !== 1'b0) begin bad++;
      $display("FAIL b_idle sdo=%0b busy=%0b exp 00 0", b_sdo, b_busy); end
  endtask

  task automatic check_reset_values(input string tag);
    total++; if (a_lr !== 1'b1 || a_sdo !== 1'b1 || a_po !== 10'h0 || a_cv !== 1'b0 ||
                 a_done !== 1'b0 || a_ovr !== 1'b0 || a_busy !== 1'b0 || a_cnt !== 4'd0) begin bad++;
      $display("FAIL %s_a lr=%0b sdo=%0b po=%03h cv=%0b done=%0b ovr=%0b busy=%0b cnt=%0d exp 1 1 000 0 0 0 0 0",
               tag, a_lr, a_sdo, a_po, a_cv, a_done, a_ovr, a_busy, a_cnt); end
    total++; if (b_lr !== 1'b1 || b_sdo !== 2'b00 || b_po !== 10'h0 || b_cv !== 1'b0 ||
                 b_busy !== 1'b0 || b_cnt !== 3'd0) begin bad++;
      $display("FAIL %s_b lr=%0b sdo=%0b po=%03h cv=%0b busy=%0b cnt=%0d exp 1 00 000 0 0 0",
               tag, b_lr, b_sdo, b_po, b_cv, b_busy, b_cnt); end
  endtask

  task automatic do_reset;
    a_lv = 0; a_sh = 0; a_ab = 0; a_cr = 0; b_lv = 0; b_sh = 0; b_ab = 0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    tick;
  endtask

  task automatic test_directed_left;
    a_cr = 1'b1;
    xfer_a(10'h2C5, 10'h2AA, 1'b0, 1'b1);
  endtask

  task automatic test_directed_right;
    xfer_b(10'h2C5, 10'h3FF);
  endtask

  task automatic test_random;
    a_cr = 1'b1;
    for (int i = 0; i < 6; i++) xfer_a(10'($urandom), 10'($urandom), 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) xfer_b(10'($urandom), 10'($urandom));
  endtask

  task automatic test_back_to_back;
    logic [9:0] w1, w2, r1, r2;
    logic [3:0] l;
    int d1, d2;
    w1 = 10'($urandom); w2 = 10'($urandom); r1 = 10'($urandom); r2 = 10'($urandom);
    a_cr = 1'b1;
    a_lv = 1'b1; a_pd = w1; a_sh = 1'b0;
    tick;
    a_pd = w2;  // next word presented with load_valid held high
    d1 = -1; d2 = -1;
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 10; k++) begin
        l = lane_of(n == 0 ? w1 : w2, k, 1, 1'b1);
        a_sh = 1'b1;
        a_sdi = lane_of(n == 0 ? r1 : r2, k, 1, 1'b1) & 4'h1 ? 1'b1 : 1'b0;
        if (n == 1) a_lv = 1'b0;
        #1;
        total++; if (a_busy !== 1'b1 || a_sdo !== l[0:0]) begin bad++;
          $display("FAIL b2b_stream n=%0d k=%0d busy=%0b sdo=%0b exp 1 %0b", n, k, a_busy, a_sdo, l[0]); end
        total++; if (a_lr !== (k == 9)) begin bad++;
          $display("FAIL b2b_load_ready n=%0d k=%0d got=%0b exp=%0b", n, k, a_lr, (k == 9)); end
        tick;
        if (a_done === 1'b1) begin if (d1 < 0) d1 = cyc; else d2 = cyc; end
      end
      total++; if (a_po !== (n == 0 ? r1 : r2)) begin bad++;
        $display("FAIL b2b_pdata n=%0d got=%03h exp=%03h", n, a_po, (n == 0 ? r1 : r2)); end
    end
    a_sh = 1'b0;
    total++; if (d1 < 0 || d2 < 0 || (d2 - d1) !== 10) begin bad++;
      $display("FAIL b2b_done_spacing d1=%0d d2=%0d exp spacing 10", d1, d2); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL b2b_end_busy got=%0b exp=0", a_busy); end
    tick;
  endtask

  task automatic test_overrun;
    logic [9:0] r1, r2;
    r1 = 10'($urandom); r2 = ~r1;
    do_reset;
    a_cr = 1'b0;
    xfer_a(10'($urandom), r1, 1'b0, 1'b0);
    total++; if (a_ovr !== 1'b0) begin bad++; $display("FAIL ovr_first got=%0b exp=0", a_ovr); end
    xfer_a(10'($urandom), r2, 1'b0, 1'b0);
    total++; if (a_ovr !== 1'b1 || a_po !== r2) begin bad++;
      $display("FAIL ovr_second ovr=%0b po=%03h exp 1 %03h", a_ovr, a_po, r2); end
    tick;
    total++; if (a_ovr !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%0b exp=1", a_ovr); end
    do_reset;
    a_cr = 1'b0;
    xfer_a(10'($urandom), r1, 1'b0, 1'b0);
    xfer_a(10'($urandom), r2, 1'b0, 1'b1);
    a_cr = 1'b0;
    total++; if (a_ovr !== 1'b0 || a_po !== r2) begin bad++;
      $display("FAIL ovr_pop_same_cycle ovr=%0b po=%03h exp 0 %03h", a_ovr, a_po, r2); end
  endtask

  task automatic test_abort;
    logic       cv_before;
    logic [9:0] po_before;
    a_cr = 1'b0;
    cv_before = a_cv; po_before = a_po;
    a_lv = 1'b1; a_pd = 10'($urandom); a_sh = 1'b0;
    tick;
    a_lv = 1'b0;
    for (int k = 0; k < 4; k++) begin a_sh = 1'b1; a_sdi = 1'($urandom); tick; end
    a_ab = 1'b1; a_sh = 1'b1; a_lv = 1'b1; #1;
    total++; if (a_lr !== 1'b0 || a_cnt !== 4'd4) begin bad++;
      $display("FAIL abort_cycle lr=%0b cnt=%0d exp 0 4", a_lr, a_cnt); end
    tick;
    a_ab = 1'b0; a_sh = 1'b0; a_lv = 1'b0;
    total++; if (a_busy !== 1'b0 || a_sdo !== 1'b1 || a_done !== 1'b0 || a_cnt !== 4'd0) begin bad++;
      $display("FAIL abort_idle busy=%0b sdo=%0b done=%0b cnt=%0d exp 0 1 0 0", a_busy, a_sdo, a_done, a_cnt); end
    total++; if (a_cv !== cv_before || a_po !== po_before) begin bad++;
      $display("FAIL abort_holding cv=%0b po=%03h exp %0b %03h", a_cv, a_po, cv_before, po_before); end
    a_cr = 1'b1;
    xfer_a(10'($urandom), 10'($urandom), 1'b1, 1'b1);
  endtask

  task automatic test_async_reset;
    a_cr = 1'b0;
    a_lv = 1'b1; a_pd = 10'($urandom); a_sh = 1'b0;
    tick;
    a_lv = 1'b0;
    for (int k = 0; k < 6; k++) begin a_sh = 1'b1; a_sdi = 1'($urandom); tick; end
    #2 rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    rst = 1'b0; a_sh = 1'b0;
    tick;
    total++; if (a_cv !== 1'b0 || a_po !== 10'h0 || a_busy !== 1'b0) begin bad++;
      $display("FAIL async_no_capture cv=%0b po=%03h busy=%0b exp 0 000 0", a_cv, a_po, a_busy); end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst = 1'b1;
    a_lv = 0; a_pd = '0; a_sh = 0; a_ab = 0; a_sdi = '0; a_cr = 0;
    b_lv = 0; b_pd = '0; b_sh = 0; b_ab = 0; b_sdi = '0; b_cr = 0;
    @(negedge clk);
    test_reset;
    test_directed_left;
    test_directed_right;
    test_random;
    test_back_to_back;
    test_overrun;
    test_abort;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
